// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states,
// owner encoding and the data/address width.
package mem_arb_pkg;

    localparam int unsigned DW = 32;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RESP_I,
        RESP_D
    } state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Tie-break between fetch and data requests.
// Ports: ireq_i/dreq_i requests, last_i last owner, win_o winner.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin ties,
// otherwise the data port always wins a tie.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic ireq_i,
    input  logic dreq_i,
    input  logic last_i,
    output logic win_o
);

    logic tie_win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign tie_win = (last_i == OWN_D) ? OWN_I : OWN_D;
`else
    assign tie_win = OWN_D;
`endif

    // With no request the previous owner is reported unchanged.
    always_comb begin
        win_o = last_i;
        unique case (1'b1)
            (ireq_i && dreq_i):  win_o = tie_win;
            (dreq_i && !ireq_i): win_o = OWN_D;
            (ireq_i && !dreq_i): win_o = OWN_I;
            default:             win_o = last_i;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port.
// Ports: clk_i, reset_i (sync, active-high); fetch ireq_i/iaddr_i,
// iready_o/irdata_o; data dreq_i/dwrite_i/daddr_i/dwdata_i,
// dready_o/drdata_o; memory mread_o/mwrite_o/maddr_o/mwdata_o,
// mrdata_i/mack_i; grant_o current owner (1 = data).
// Build option: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          ireq_i,
    input  logic [DW-1:0] iaddr_i,
    output logic          iready_o,
    output logic [DW-1:0] irdata_o,
    input  logic          dreq_i,
    input  logic          dwrite_i,
    input  logic [DW-1:0] daddr_i,
    input  logic [DW-1:0] dwdata_i,
    output logic          dready_o,
    output logic [DW-1:0] drdata_o,
    output logic          mread_o,
    output logic          mwrite_o,
    output logic [DW-1:0] maddr_o,
    output logic [DW-1:0] mwdata_o,
    input  logic [DW-1:0] mrdata_i,
    input  logic          mack_i,
    output logic          grant_o
);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] maddr_q, maddr_d;
    logic [DW-1:0] mwdata_q, mwdata_d;
    logic [DW-1:0] irdata_q, irdata_d;
    logic [DW-1:0] drdata_q, drdata_d;
    logic          win;

    mem_arb_pick u_pick (
        .ireq_i (ireq_i),
        .dreq_i (dreq_i),
        .last_i (owner_q),
        .win_o  (win)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            owner_q  <= OWN_I;
            wr_q     <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        unique case (state_q)
            IDLE: begin
                if (ireq_i || dreq_i) begin
                    owner_d = win;
                    if (win == OWN_D) begin
                        maddr_d  = daddr_i;
                        mwdata_d = dwdata_i;
                        wr_d     = dwrite_i;
                        state_d  = SERVE_D;
                    end else begin
                        maddr_d = iaddr_i;
                        wr_d    = 1'b0;
                        state_d = SERVE_I;
                    end
                end
            end
            SERVE_I: begin
                if (mack_i) begin
                    irdata_d = mrdata_i;
                    state_d  = RESP_I;
                end
            end
            SERVE_D: begin
                if (mack_i) begin
                    // Write acks carry no data; keep the last read word.
                    if (!wr_q) drdata_d = mrdata_i;
                    state_d = RESP_D;
                end
            end
            RESP_I:  state_d = IDLE;
            RESP_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mread_o  = (state_q == SERVE_I) ||
                      ((state_q == SERVE_D) && !wr_q);
    assign mwrite_o = (state_q == SERVE_D) && wr_q;
    assign iready_o = (state_q == RESP_I);
    assign dready_o = (state_q == RESP_D);
    assign maddr_o  = maddr_q;
    assign mwdata_o = mwdata_q;
    assign irdata_o = irdata_q;
    assign drdata_o = drdata_q;
    assign grant_o  = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        ireq_i;
    logic [31:0] iaddr_i;
    logic        iready_o;
    logic [31:0] irdata_o;
    logic        dreq_i;
    logic        dwrite_i;
    logic [31:0] daddr_i;
    logic [31:0] dwdata_i;
    logic        dready_o;
    logic [31:0] drdata_o;
    logic        mread_o;
    logic        mwrite_o;
    logic [31:0] maddr_o;
    logic [31:0] mwdata_o;
    logic [31:0] mrdata_i;
    logic        mack_i;
    logic        grant_o;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .ireq_i   (ireq_i),
        .iaddr_i  (iaddr_i),
        .iready_o (iready_o),
        .irdata_o (irdata_o),
        .dreq_i   (dreq_i),
        .dwrite_i (dwrite_i),
        .daddr_i  (daddr_i),
        .dwdata_i (dwdata_i),
        .dready_o (dready_o),
        .drdata_o (drdata_o),
        .mread_o  (mread_o),
        .mwrite_o (mwrite_o),
        .maddr_o  (maddr_o),
        .mwdata_o (mwdata_o),
        .mrdata_i (mrdata_i),
        .mack_i   (mack_i),
        .grant_o  (grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    // Called in an IDLE cycle with the request(s) already driven;
    // returns in the RESP cycle.
    task automatic run_acc(input string tag, input logic own,
                           input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata,
                           input logic [31:0] rd, input int lat);
        tick();
        chk({tag, ".grant"}, 32'(grant_o), 32'(own));
        chk({tag, ".mread"}, 32'(mread_o), 32'(!wr));
        chk({tag, ".mwrite"}, 32'(mwrite_o), 32'(wr));
        chk({tag, ".maddr"}, maddr_o, addr);
        if (wr) chk({tag, ".mwdata"}, mwdata_o, wdata);
        for (int i = 1; i < lat; i++) begin
            tick();
            chk({tag, ".hold"}, 32'(mread_o | mwrite_o), 32'd1);
        end
        mack_i   = 1'b1;
        mrdata_i = rd;
        tick();
        mack_i   = 1'b0;
        mrdata_i = 32'h0;
        chk({tag, ".iready"}, 32'(iready_o), 32'(own == 1'b0));
        chk({tag, ".dready"}, 32'(dready_o), 32'(own == 1'b1));
        chk({tag, ".strb_off"}, 32'(mread_o | mwrite_o), 32'd0);
        chk({tag, ".grant_r"}, 32'(grant_o), 32'(own));
        if (own == 1'b0) chk({tag, ".irdata"}, irdata_o, rd);
        else if (!wr) chk({tag, ".drdata"}, drdata_o, rd);
    endtask

    logic exp_own [4];

    initial begin
        reset_i  = 1'b1;
        ireq_i   = 1'b0;
        iaddr_i  = 32'h0;
        dreq_i   = 1'b0;
        dwrite_i = 1'b0;
        daddr_i  = 32'h0;
        dwdata_i = 32'h0;
        mrdata_i = 32'h0;
        mack_i   = 1'b0;
        do_reset();

        chk("rst.mread", 32'(mread_o), 32'd0);
        chk("rst.mwrite", 32'(mwrite_o), 32'd0);
        chk("rst.iready", 32'(iready_o), 32'd0);
        chk("rst.dready", 32'(dready_o), 32'd0);
        chk("rst.maddr", maddr_o, 32'h0);
        chk("rst.mwdata", mwdata_o, 32'h0);
        chk("rst.irdata", irdata_o, 32'h0);
        chk("rst.drdata", drdata_o, 32'h0);
        chk("rst.grant", 32'(grant_o), 32'd0);

        // Fetch, ack three cycles after the strobe starts.
        ireq_i  = 1'b1;
        iaddr_i = 32'h100;
        run_acc("fetch", 1'b0, 1'b0, 32'h100, 32'h0,
                32'hDEADBEEF, 4);
        ireq_i = 1'b0;
        tick();
        chk("fetch.once", 32'(iready_o), 32'd0);
        chk("fetch.hold", irdata_o, 32'hDEADBEEF);

        // Data write; read-data register must not move.
        dreq_i   = 1'b1;
        dwrite_i = 1'b1;
        daddr_i  = 32'h200;
        dwdata_i = 32'h12345678;
        run_acc("dwr", 1'b1, 1'b1, 32'h200, 32'h12345678,
                32'hFFFFFFFF, 2);
        dreq_i   = 1'b0;
        dwrite_i = 1'b0;
        chk("dwr.drdata", drdata_o, 32'h0);
        tick();
        chk("dwr.once", 32'(dready_o), 32'd0);
        chk("dwr.grant_idle", 32'(grant_o), 32'd1);
        chk("dwr.irdata", irdata_o, 32'hDEADBEEF);

        // Both ports held for four accesses.
        do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        ireq_i  = 1'b1;
        iaddr_i = 32'h400;
        dreq_i  = 1'b1;
        daddr_i = 32'h300;
        for (int n = 0; n < 4; n++) begin
            run_acc($sformatf("tie%0d", n), exp_own[n], 1'b0,
                    exp_own[n] ? 32'h300 : 32'h400, 32'h0,
                    32'hA0000000 + 32'(n), 1);
            tick();
        end
        ireq_i = 1'b0;
        dreq_i = 1'b0;

        // Reset in the middle of a data read, then a late ack.
        daddr_i = 32'h500;
        dreq_i  = 1'b1;
        tick();
        chk("rst_mid.mread", 32'(mread_o), 32'd1);
        chk("rst_mid.grant", 32'(grant_o), 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i  = 1'b0;
        dreq_i   = 1'b0;
        mack_i   = 1'b1;
        mrdata_i = 32'h00000BAD;
        chk("rst_mid.strb", 32'(mread_o | mwrite_o), 32'd0);
        chk("rst_mid.dready0", 32'(dready_o), 32'd0);
        tick();
        mack_i   = 1'b0;
        mrdata_i = 32'h0;
        chk("rst_mid.dready1", 32'(dready_o), 32'd0);
        chk("rst_mid.drdata", drdata_o, 32'h0);
        chk("rst_mid.strb1", 32'(mread_o | mwrite_o), 32'd0);
        tick();
        chk("rst_mid.dready2", 32'(dready_o), 32'd0);
        ireq_i  = 1'b1;
        iaddr_i = 32'h600;
        run_acc("after_rst", 1'b0, 1'b0, 32'h600, 32'h0,
                32'h66, 1);
        ireq_i = 1'b0;
        tick();

        // Spurious ack in IDLE, then fetch dropped mid-service.
        mack_i   = 1'b1;
        mrdata_i = 32'h55;
        tick();
        mack_i   = 1'b0;
        mrdata_i = 32'h0;
        chk("spur.iready", 32'(iready_o), 32'd0);
        chk("spur.dready", 32'(dready_o), 32'd0);
        chk("spur.mread", 32'(mread_o), 32'd0);
        chk("spur.irdata", irdata_o, 32'h66);
        ireq_i  = 1'b1;
        iaddr_i = 32'h700;
        tick();
        chk("drop.mread0", 32'(mread_o), 32'd1);
        ireq_i = 1'b0;
        tick();
        chk("drop.mread1", 32'(mread_o), 32'd1);
        chk("drop.maddr", maddr_o, 32'h700);
        mack_i   = 1'b1;
        mrdata_i = 32'h77;
        tick();
        mack_i   = 1'b0;
        mrdata_i = 32'h0;
        chk("drop.iready", 32'(iready_o), 32'd1);
        chk("drop.irdata", irdata_o, 32'h77);
        tick();
        chk("drop.once", 32'(iready_o), 32'd0);
        tick();
        chk("drop.idle", 32'(iready_o | mread_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
